// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and sizing for the cache-to-memory request arbiter.
// Serial widths bound how many read/write transactions can be in flight at once.
package mem_access_arbiter_pkg;

  localparam int unsigned MSHR_NUM                   = 2;
  localparam int unsigned MEM_READ_SERIAL_NUM        = MSHR_NUM + 1;
  localparam int unsigned MEM_WRITE_SERIAL_NUM       = MSHR_NUM;
  localparam int unsigned MEM_ACCESS_SERIAL_BIT_SIZE = 2;
  localparam int unsigned MEM_WRITE_SERIAL_BIT_SIZE  = 1;
  localparam int unsigned MEM_IC_MAX_OUTSTANDING     = 1;
  localparam int unsigned ADDR_BIT_SIZE              = 32;
  localparam int unsigned LINE_BIT_SIZE              = 64;

  typedef logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] MemAccessSerial;
  typedef logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0]  MemWriteSerial;
  typedef logic [ADDR_BIT_SIZE-1:0]              Addr;
  typedef logic [LINE_BIT_SIZE-1:0]              LineData;

  typedef enum logic [1:0] {
    MEM_OWNER_NONE,
    MEM_OWNER_IC,
    MEM_OWNER_DC
  } MemAccessOwner;

  typedef struct packed {
    logic valid;
    Addr  addr;
  } MemReadAccessReq;

  typedef struct packed {
    logic    valid;
    logic    we;
    Addr     addr;
    LineData data;
  } MemAccessReq;

  typedef struct packed {
    logic           ack;
    MemAccessSerial serial;
    MemWriteSerial  wserial;
  } MemAccessReqAck;

  typedef struct packed {
    logic           valid;
    MemAccessSerial serial;
    LineData        data;
  } MemAccessResult;

  typedef struct packed {
    logic          valid;
    MemWriteSerial serial;
  } MemAccessResponse;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of cache-side and memory-side request/response signals around the arbiter.
// master is the arbiter's view; slave is the surrounding caches and memory bridge.
interface mem_access_arbiter_if;
  import mem_access_arbiter_pkg::*;

  MemReadAccessReq  icReq;
  MemAccessReqAck   icAck;
  MemAccessReq      dcReq;
  MemAccessReqAck   dcAck;
  MemAccessReq      memReq;
  MemAccessSerial   memReqSerial;
  MemWriteSerial    memReqWSerial;
  logic             memReady;
  MemAccessResult   memResult;
  MemAccessResponse memResponse;
  MemAccessResult   icResult;
  MemAccessResult   dcResult;
  MemAccessResponse dcResponse;

  modport master (
    input  icReq, dcReq, memReady, memResult, memResponse,
    output icAck, dcAck, memReq, memReqSerial, memReqWSerial,
           icResult, dcResult, dcResponse
  );

  modport slave (
    output icReq, dcReq, memReady, memResult, memResponse,
    input  icAck, dcAck, memReq, memReqSerial, memReqWSerial,
           icResult, dcResult, dcResponse
  );

endinterface

// File: rtl/mem_access_arbiter_serial_free_list.sv
// Busy mask for a pool of transaction serials with a lowest-index-free picker.
// The picker looks only at the registered mask, so a serial freed this cycle is offered next cycle.
module serial_free_list #(
  parameter int unsigned NUM   = 3,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             free,
  input  logic [WIDTH-1:0] freeSerial,
  output logic [WIDTH-1:0] allocSerial,
  output logic             hasFree,
  output logic [NUM-1:0]   busy
);

  logic [NUM-1:0] busyNext;

  always_comb begin
    hasFree     = 1'b0;
    allocSerial = '0;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        hasFree     = 1'b1;
        allocSerial = WIDTH'(i);
      end
    end
  end

  // Alloc and free never target the same serial: alloc picks idle, free hits busy.
  always_comb begin
    busyNext = busy;
    for (int i = 0; i < int'(NUM); i++) begin
      if (free && freeSerial == WIDTH'(i)) busyNext[i] = 1'b0;
      if (alloc && allocSerial == WIDTH'(i)) busyNext[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busyNext;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory request port between ICache line fills and DCache reads/writes,
// hands out read/write serials and routes read data back to whichever cache issued it.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned READ_SERIAL_NUM    = MEM_READ_SERIAL_NUM,
  parameter int unsigned WRITE_SERIAL_NUM   = MEM_WRITE_SERIAL_NUM,
  parameter int unsigned IC_MAX_OUTSTANDING = MEM_IC_MAX_OUTSTANDING
) (
  input logic                  clk,
  input logic                  rst,
  mem_access_arbiter_if.master bus
);

  localparam int unsigned IC_COUNT_BIT_SIZE = $clog2(IC_MAX_OUTSTANDING + 1);

  logic                          rdHasFree;
  logic                          wrHasFree;
  MemAccessSerial                rdFreeSerial;
  MemWriteSerial                 wrFreeSerial;
  logic [READ_SERIAL_NUM-1:0]    readBusy;
  logic [WRITE_SERIAL_NUM-1:0]   writeBusy;
  MemAccessOwner                 readOwner [READ_SERIAL_NUM];
  logic [IC_COUNT_BIT_SIZE-1:0]  icOutCount;
  MemAccessOwner                 lastGrant;

  logic          icEligible;
  logic          dcEligible;
  logic          icGrant;
  logic          dcGrant;
  logic          accepted;
  logic          rdAlloc;
  logic          wrAlloc;
  logic          rdRelease;
  logic          wrRelease;
  logic          icIssue;
  logic          icRetire;
  MemAccessOwner resultOwner;
  logic          responseBusy;

  serial_free_list #(
    .NUM   (READ_SERIAL_NUM),
    .WIDTH (MEM_ACCESS_SERIAL_BIT_SIZE)
  ) readSerials (
    .clk         (clk),
    .rst         (rst),
    .alloc       (rdAlloc),
    .free        (rdRelease),
    .freeSerial  (bus.memResult.serial),
    .allocSerial (rdFreeSerial),
    .hasFree     (rdHasFree),
    .busy        (readBusy)
  );

  serial_free_list #(
    .NUM   (WRITE_SERIAL_NUM),
    .WIDTH (MEM_WRITE_SERIAL_BIT_SIZE)
  ) writeSerials (
    .clk         (clk),
    .rst         (rst),
    .alloc       (wrAlloc),
    .free        (wrRelease),
    .freeSerial  (bus.memResponse.serial),
    .allocSerial (wrFreeSerial),
    .hasFree     (wrHasFree),
    .busy        (writeBusy)
  );

  // Round-robin between the two caches; ties go to whoever was not acked last.
  always_comb begin
    icEligible = bus.icReq.valid && rdHasFree &&
                 (icOutCount < IC_COUNT_BIT_SIZE'(IC_MAX_OUTSTANDING));
    dcEligible = bus.dcReq.valid && (bus.dcReq.we ? wrHasFree : rdHasFree);
    icGrant    = icEligible && (!dcEligible || lastGrant == MEM_OWNER_DC);
    dcGrant    = dcEligible && (!icEligible || lastGrant == MEM_OWNER_IC);
    accepted   = bus.memReady && (icGrant || dcGrant);
    rdAlloc    = bus.memReady && (icGrant || (dcGrant && !bus.dcReq.we));
    wrAlloc    = bus.memReady && dcGrant && bus.dcReq.we;
    icIssue    = bus.memReady && icGrant;
  end

  always_comb begin
    bus.memReq        = '0;
    bus.memReqSerial  = '0;
    bus.memReqWSerial = '0;
    bus.icAck         = '0;
    bus.dcAck         = '0;
    if (icGrant) begin
      bus.memReq.valid = 1'b1;
      bus.memReq.addr  = bus.icReq.addr;
      bus.memReqSerial = rdFreeSerial;
    end else if (dcGrant) begin
      bus.memReq       = bus.dcReq;
      bus.memReq.valid = 1'b1;
      if (bus.dcReq.we) bus.memReqWSerial = wrFreeSerial;
      else              bus.memReqSerial  = rdFreeSerial;
    end
    if (icGrant && bus.memReady) begin
      bus.icAck.ack    = 1'b1;
      bus.icAck.serial = rdFreeSerial;
    end
    if (dcGrant && bus.memReady) begin
      bus.dcAck.ack = 1'b1;
      if (bus.dcReq.we) bus.dcAck.wserial = wrFreeSerial;
      else              bus.dcAck.serial  = rdFreeSerial;
    end
  end

  // Completions for idle serials resolve to no owner and are dropped.
  always_comb begin
    resultOwner  = MEM_OWNER_NONE;
    responseBusy = 1'b0;
    for (int i = 0; i < int'(READ_SERIAL_NUM); i++) begin
      if (readBusy[i] && bus.memResult.serial == MemAccessSerial'(i))
        resultOwner = readOwner[i];
    end
    for (int i = 0; i < int'(WRITE_SERIAL_NUM); i++) begin
      if (writeBusy[i] && bus.memResponse.serial == MemWriteSerial'(i))
        responseBusy = 1'b1;
    end
  end

  always_comb begin
    rdRelease      = bus.memResult.valid && resultOwner != MEM_OWNER_NONE;
    wrRelease      = bus.memResponse.valid && responseBusy;
    icRetire       = rdRelease && resultOwner == MEM_OWNER_IC;
    bus.icResult   = '0;
    bus.dcResult   = '0;
    bus.dcResponse = '0;
    if (rdRelease && resultOwner == MEM_OWNER_IC) bus.icResult = bus.memResult;
    if (rdRelease && resultOwner == MEM_OWNER_DC) bus.dcResult = bus.memResult;
    if (wrRelease) bus.dcResponse = bus.memResponse;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(READ_SERIAL_NUM); i++) readOwner[i] <= MEM_OWNER_NONE;
    end else begin
      for (int i = 0; i < int'(READ_SERIAL_NUM); i++) begin
        if (rdRelease && bus.memResult.serial == MemAccessSerial'(i))
          readOwner[i] <= MEM_OWNER_NONE;
        if (rdAlloc && rdFreeSerial == MemAccessSerial'(i))
          readOwner[i] <= icGrant ? MEM_OWNER_IC : MEM_OWNER_DC;
      end
    end
  end

  // Issue and retire in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     icOutCount <= '0;
    else if (icIssue && !icRetire) icOutCount <= icOutCount + IC_COUNT_BIT_SIZE'(1);
    else if (!icIssue && icRetire) icOutCount <= icOutCount - IC_COUNT_BIT_SIZE'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lastGrant <= MEM_OWNER_DC;
    else if (accepted) lastGrant <= icGrant ? MEM_OWNER_IC : MEM_OWNER_DC;
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.memResult.valid)
      assert (resultOwner != MEM_OWNER_NONE)
        else $warning("memResult for idle serial %0d dropped", bus.memResult.serial);
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle checked against a serial-pool reference model.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int RN       = int'(MEM_READ_SERIAL_NUM);
  localparam int WN       = int'(MEM_WRITE_SERIAL_NUM);
  localparam int OWN_NONE = 0;
  localparam int OWN_IC   = 1;
  localparam int OWN_DC   = 2;
  localparam int RANDOM_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_arbiter_if bus ();

  mem_access_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus
  logic           icV, dcV, dcWe, rdy, resV, rspV;
  Addr            icAddr, dcAddr;
  LineData        dcData, resData;
  MemAccessSerial resSerial;
  MemWriteSerial  rspSerial;

  // reference model: which serials are taken and by whom
  bit mRdBusy  [RN];
  int mRdOwner [RN];
  bit mWrBusy  [WN];
  int mIcOut;
  int mLast;

  // per-cycle expected handshakes and observed outputs
  bit               eIcAck, eDcAck;
  MemAccessReqAck   oIcAck, oDcAck;
  MemAccessResult   oIcRes, oDcRes;

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic MemAccessReqAck mkAck(input logic a, input int s, input int w);
    MemAccessReqAck r;
    r.ack     = a;
    r.serial  = MemAccessSerial'(s);
    r.wserial = MemWriteSerial'(w);
    return r;
  endfunction

  task automatic idle();
    icV = 0; icAddr = '0; dcV = 0; dcWe = 0; dcAddr = '0; dcData = '0; rdy = 0;
    resV = 0; resSerial = '0; resData = '0; rspV = 0; rspSerial = '0;
  endtask

  task automatic drive();
    bus.icReq.valid         = icV;
    bus.icReq.addr          = icAddr;
    bus.dcReq.valid         = dcV;
    bus.dcReq.we            = dcWe;
    bus.dcReq.addr          = dcAddr;
    bus.dcReq.data          = dcData;
    bus.memReady            = rdy;
    bus.memResult.valid     = resV;
    bus.memResult.serial    = resSerial;
    bus.memResult.data      = resData;
    bus.memResponse.valid   = rspV;
    bus.memResponse.serial  = rspSerial;
  endtask

  task automatic modelReset();
    for (int i = 0; i < RN; i++) begin mRdBusy[i] = 0; mRdOwner[i] = OWN_NONE; end
    for (int i = 0; i < WN; i++) mWrBusy[i] = 0;
    mIcOut = 0;
    mLast  = OWN_DC;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1;
    idle();
    drive();
    modelReset();
    #1;
    checkEq("rst memReq", 128'(bus.memReq), 128'(0));
    checkEq("rst acks", 128'({bus.icAck, bus.dcAck}), 128'(0));
    checkEq("rst results", 128'({bus.icResult, bus.dcResult, bus.dcResponse}), 128'(0));
    @(negedge clk);
    rst = 0;
  endtask

  // One clock: apply inputs, compare every output with the model, then advance the model.
  task automatic step();
    MemAccessReq      eReq;
    MemAccessSerial   eSer;
    MemWriteSerial    eWSer;
    MemAccessReqAck   eIc, eDc;
    MemAccessResult   eIcR, eDcR;
    MemAccessResponse eRsp;
    int  fr, fw, win, owner;
    bit  icE, dcE, resHit, rspHit;
    @(negedge clk);
    drive();
    #1;
    fr = -1;
    for (int i = RN - 1; i >= 0; i--) if (!mRdBusy[i]) fr = i;
    fw = -1;
    for (int i = WN - 1; i >= 0; i--) if (!mWrBusy[i]) fw = i;
    icE = icV && mIcOut < int'(MEM_IC_MAX_OUTSTANDING) && fr >= 0;
    dcE = dcV && (dcWe ? fw >= 0 : fr >= 0);
    if (icE && dcE) win = (mLast == OWN_IC) ? OWN_DC : OWN_IC;
    else if (icE)   win = OWN_IC;
    else if (dcE)   win = OWN_DC;
    else            win = OWN_NONE;

    eReq = '0; eSer = '0; eWSer = '0; eIc = '0; eDc = '0;
    if (win == OWN_IC) begin
      eReq.valid = 1; eReq.addr = icAddr; eSer = MemAccessSerial'(fr);
      if (rdy) eIc = mkAck(1, fr, 0);
    end
    if (win == OWN_DC) begin
      eReq.valid = 1; eReq.we = dcWe; eReq.addr = dcAddr; eReq.data = dcData;
      if (dcWe) eWSer = MemWriteSerial'(fw); else eSer = MemAccessSerial'(fr);
      if (rdy) eDc = dcWe ? mkAck(1, 0, fw) : mkAck(1, fr, 0);
    end

    resHit = 0; owner = OWN_NONE;
    if (resV && int'(resSerial) < RN && mRdBusy[int'(resSerial)]) begin
      resHit = 1; owner = mRdOwner[int'(resSerial)];
    end
    eIcR = '0; eDcR = '0;
    if (resHit && owner == OWN_IC) begin eIcR.valid = 1; eIcR.serial = resSerial; eIcR.data = resData; end
    if (resHit && owner == OWN_DC) begin eDcR.valid = 1; eDcR.serial = resSerial; eDcR.data = resData; end
    rspHit = rspV && int'(rspSerial) < WN && mWrBusy[int'(rspSerial)];
    eRsp = '0;
    if (rspHit) begin eRsp.valid = 1; eRsp.serial = rspSerial; end

    checkEq("memReq", 128'(bus.memReq), 128'(eReq));
    checkEq("memReqSerials", 128'({bus.memReqSerial, bus.memReqWSerial}), 128'({eSer, eWSer}));
    checkEq("icAck", 128'(bus.icAck), 128'(eIc));
    checkEq("dcAck", 128'(bus.dcAck), 128'(eDc));
    checkEq("icResult", 128'(bus.icResult), 128'(eIcR));
    checkEq("dcResult", 128'(bus.dcResult), 128'(eDcR));
    checkEq("dcResponse", 128'(bus.dcResponse), 128'(eRsp));

    oIcAck = bus.icAck; oDcAck = bus.dcAck; oIcRes = bus.icResult; oDcRes = bus.dcResult;
    eIcAck = eIc.ack;   eDcAck = eDc.ack;

    if (resHit) begin
      if (owner == OWN_IC) mIcOut--;
      mRdBusy[int'(resSerial)] = 0; mRdOwner[int'(resSerial)] = OWN_NONE;
    end
    if (rspHit) mWrBusy[int'(rspSerial)] = 0;
    if (eIc.ack) begin
      mRdBusy[fr] = 1; mRdOwner[fr] = OWN_IC; mIcOut++; mLast = OWN_IC;
    end
    if (eDc.ack) begin
      if (dcWe) mWrBusy[fw] = 1;
      else begin mRdBusy[fr] = 1; mRdOwner[fr] = OWN_DC; end
      mLast = OWN_DC;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    int cand[$];
    idle();
    drive();
    doReset();

    // first IC line fill gets serial 0 and its data routes back to IC
    icV = 1; icAddr = 32'h1000; rdy = 1;
    step();
    checkEq("t1 icAck", 128'(oIcAck), 128'(mkAck(1, 0, 0)));
    icV = 0; resV = 1; resSerial = '0; resData = 64'hA5A5_0000_1234_5678;
    step();
    checkEq("t1 icResult.valid", 128'(oIcRes.valid), 128'(1));
    checkEq("t1 dcResult.valid", 128'(oDcRes.valid), 128'(0));

    // IC was acked last, so contention alternates starting with DC
    icV = 1; icAddr = 32'h2000; dcV = 1; dcWe = 0; dcAddr = 32'h3000; rdy = 1; resV = 0;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      resV = (prev >= 0); resSerial = MemAccessSerial'(prev < 0 ? 0 : prev);
      step();
      checkEq($sformatf("t2 grant%0d", k), 128'({oIcAck.ack, oDcAck.ack}),
              128'((k % 2 == 0) ? 2'b01 : 2'b10));
      prev = oIcAck.ack ? int'(oIcAck.serial) : int'(oDcAck.serial);
    end
    idle(); resV = 1; resSerial = MemAccessSerial'(prev);
    step();
    idle();

    // read pool exhaustion blocks reads but not writes
    doReset();
    dcV = 1; dcWe = 0; rdy = 1;
    for (int k = 0; k < 3; k++) begin
      dcAddr = Addr'(32'h4000 + k * 64);
      step();
      checkEq($sformatf("t3 serial%0d", k), 128'(oDcAck), 128'(mkAck(1, k, 0)));
    end
    icV = 1; icAddr = 32'h5000; dcAddr = 32'h4100;
    step();
    checkEq("t3 full acks", 128'({oIcAck.ack, oDcAck.ack}), 128'(0));
    dcWe = 1; dcData = 64'h1234;
    step();
    checkEq("t3 write ack", 128'(oDcAck), 128'(mkAck(1, 0, 0)));
    checkEq("t3 ic blocked", 128'(oIcAck.ack), 128'(0));
    idle();

    // backpressure holds the request without side effects
    doReset();
    icV = 1; icAddr = 32'h6000; rdy = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkEq($sformatf("t4 stall%0d", k), 128'(oIcAck.ack), 128'(0));
    end
    rdy = 1;
    step();
    checkEq("t4 ack", 128'(oIcAck), 128'(mkAck(1, 0, 0)));
    idle();

    // serial freed this cycle is skipped, reused next cycle
    doReset();
    dcV = 1; dcWe = 0; dcAddr = 32'h7000; rdy = 1;
    step();
    step();
    resV = 1; resSerial = MemAccessSerial'(1); resData = 64'hBEEF;
    step();
    checkEq("t5 skip freed", 128'(oDcAck), 128'(mkAck(1, 2, 0)));
    checkEq("t5 dcResult", 128'(oDcRes.valid), 128'(1));
    resV = 0;
    step();
    checkEq("t5 reuse", 128'(oDcAck), 128'(mkAck(1, 1, 0)));
    idle();

    // reset with traffic in flight frees everything; late data is dropped
    doReset();
    dcV = 1; dcWe = 0; dcAddr = 32'h8000; rdy = 1;
    step();
    dcV = 0; icV = 1; icAddr = 32'h9000;
    step();
    icV = 0; dcV = 1; dcWe = 1; dcData = 64'h55;
    step();
    doReset();
    resV = 1; resSerial = MemAccessSerial'(1); resData = 64'hDEAD;
    step();
    checkEq("t6 stray ic", 128'(oIcRes.valid), 128'(0));
    checkEq("t6 stray dc", 128'(oDcRes.valid), 128'(0));
    resV = 0; dcV = 1; dcWe = 0; dcAddr = 32'hA000; rdy = 1;
    step();
    checkEq("t6 rd serial", 128'(oDcAck), 128'(mkAck(1, 0, 0)));
    dcWe = 1;
    step();
    checkEq("t6 wr serial", 128'(oDcAck), 128'(mkAck(1, 0, 0)));
    idle();
    doReset();

    // random traffic; completions only target serials the model holds busy
    for (int n = 0; n < RANDOM_CYCLES; n++) begin
      if (!icV && $urandom_range(2) == 0) begin
        icV = 1; icAddr = Addr'($urandom) & ~Addr'(63);
      end
      if (!dcV && $urandom_range(2) == 0) begin
        dcV = 1; dcWe = 1'($urandom_range(1)); dcAddr = Addr'($urandom) & ~Addr'(7);
        dcData = {$urandom, $urandom};
      end
      rdy = ($urandom_range(3) != 0);
      resV = 0; rspV = 0;
      cand.delete();
      for (int i = 0; i < RN; i++) if (mRdBusy[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        resV = 1;
        resSerial = MemAccessSerial'(cand[$urandom_range(cand.size() - 1)]);
        resData = {$urandom, $urandom};
      end
      cand.delete();
      for (int i = 0; i < WN; i++) if (mWrBusy[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        rspV = 1;
        rspSerial = MemWriteSerial'(cand[$urandom_range(cand.size() - 1)]);
      end
      step();
      if (eIcAck) icV = 0;
      if (eDcAck) dcV = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
